// File: rtl/fetch_queue.sv
// Sequential instruction fetch front-end with a small {pc, instr} FIFO ahead of IF/ID.
// Optional same-cycle response bypass to decode when the queue is empty: FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fifoPc_q    [DEPTH];
  logic [31:0]   fifoInstr_q [DEPTH];
  logic [PW-1:0] rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    outstanding_q, outstanding_d;
  logic [2:0]    dropCnt_q, dropCnt_d;
  logic [31:0]   fetchPc_q, fetchPc_d;
  logic [31:0]   rspPc_q, rspPc_d;

  logic        reqFire;
  logic        rspKeep;
  logic        fifoHasHead;
  logic        bypassHit;
  logic        push;
  logic        pop;
  logic [31:0] inFlight;
  logic        unusedRedirectLsbs;

  assign unusedRedirectLsbs = ^redirect_pc[1:0];

  // Credit covers queued entries plus responses that will still land in the queue.
  assign inFlight      = 32'(count_q) + 32'(outstanding_q) - 32'(dropCnt_q);
  assign mem_req_valid = !reset && !redirect_valid && (inFlight < 32'(DEPTH))
                         && (32'(outstanding_q) < 32'(MAX_OUTSTANDING));
  assign mem_req_addr  = fetchPc_q;
  assign reqFire       = mem_req_valid && mem_req_ready;
  assign rspKeep       = mem_rsp_valid && (dropCnt_q == 3'd0);
  assign fifoHasHead   = (count_q != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypassHit = rspKeep && !fifoHasHead && !redirect_valid && !reset;
`else
  assign bypassHit = 1'b0;
`endif

  assign pop  = fifoHasHead && out_ready;
  assign push = rspKeep && !(bypassHit && out_ready);

  always_comb begin
    out_valid = fifoHasHead || bypassHit;
    out_pc    = 32'h0;
    out_instr = 32'h0;
    if (fifoHasHead) begin
      out_pc    = fifoPc_q[rdPtr_q];
      out_instr = fifoInstr_q[rdPtr_q];
    end else if (bypassHit) begin
      out_pc    = rspPc_q;
      out_instr = mem_rsp_data;
    end
  end

  always_comb begin
    rdPtr_d       = rdPtr_q;
    wrPtr_d       = wrPtr_q;
    count_d       = count_q;
    fetchPc_d     = fetchPc_q;
    rspPc_d       = rspPc_q;
    dropCnt_d     = dropCnt_q;
    outstanding_d = outstanding_q + 3'(reqFire) - 3'(mem_rsp_valid);
    if (redirect_valid) begin
      // No request can fire this cycle, so everything left outstanding is stale.
      rdPtr_d   = '0;
      wrPtr_d   = '0;
      count_d   = '0;
      fetchPc_d = {redirect_pc[31:2], 2'b00};
      rspPc_d   = {redirect_pc[31:2], 2'b00};
      dropCnt_d = outstanding_d;
    end else begin
      if (reqFire) fetchPc_d = fetchPc_q + 32'd4;
      if (mem_rsp_valid && (dropCnt_q != 3'd0)) dropCnt_d = dropCnt_q - 3'd1;
      if (rspKeep) rspPc_d = rspPc_q + 32'd4;
      if (push) wrPtr_d = wrPtr_q + 1'b1;
      if (pop) rdPtr_d = rdPtr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr_q       <= '0;
      wrPtr_q       <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      dropCnt_q     <= '0;
      fetchPc_q     <= RESET_PC;
      rspPc_q       <= RESET_PC;
    end else begin
      rdPtr_q       <= rdPtr_d;
      wrPtr_q       <= wrPtr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      dropCnt_q     <= dropCnt_d;
      fetchPc_q     <= fetchPc_d;
      rspPc_q       <= rspPc_d;
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (!reset && !redirect_valid && push) begin
      fifoPc_q[wrPtr_q]    <= rspPc_q;
      fifoInstr_q[wrPtr_q] <= mem_rsp_data;
    end
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front-end placed directly upstream of the IF/ID pipeline register. It issues sequential word fetches to a pipelined instruction memory that may stall and respond with latency ≥1 cycle. Returned instructions are buffered together with their PC in a small FIFO and presented to the decode stage through a valid/ready handshake. A branch redirect flushes the queue and discards any responses still in flight.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `MAX_OUTSTANDING`, 2: maximum memory requests in flight, 1..7.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `mem_req_valid` out 1: a fetch request is presented.
- `mem_req_addr` out 32: word address of the request; bits [1:0] always 0.
- `mem_req_ready` in 1: memory accepts the request this cycle.
- `mem_rsp_valid` in 1: response data is valid. Responses return in request order and are never back-pressured.
- `mem_rsp_data` in 32: instruction word.
- `redirect_valid` in 1: the ID stage takes a branch; redirect this cycle.
- `redirect_pc` in 32: branch target; bits [1:0] are ignored and treated as 0.
- `out_valid` out 1: `out_instr` and `out_pc` are valid.
- `out_instr` out 32: instruction at the queue head.
- `out_pc` out 32: PC of `out_instr`.
- `out_ready` in 1: decode accepts the head entry (IF/ID write enable).

## Operation
State:
- `fetch_pc`: next address to request.
- `rsp_pc`: PC to assign to the next non-dropped response.
- `outstanding`: requests accepted by memory but not yet answered.
- `drop_cnt`: responses still to be discarded after a redirect.
- FIFO storing {pc, instr} pairs, with `count` entries occupied.

Request issue:
- `mem_req_valid` = !reset && !redirect_valid && (count + outstanding − drop_cnt < DEPTH) && (outstanding < MAX_OUTSTANDING).
- This credit rule guarantees every non-dropped response has a free FIFO slot.
- `mem_req_addr` = `fetch_pc`.
- On handshake (valid && ready): `fetch_pc` += 4 (mod 2^32) and `outstanding` increments.

Response handling:
- Each `mem_rsp_valid` decrements `outstanding`.
- If `drop_cnt` > 0, the response is discarded and `drop_cnt` decrements.
- Otherwise {`rsp_pc`, data} is pushed into the FIFO and `rsp_pc` += 4.

Dequeue:
- `out_valid` = count > 0. The head is popped when `out_valid && out_ready`.
- A push and a pop in the same cycle leave `count` unchanged.

Redirect (priority over pop and push in the same cycle):
- FIFO is emptied.
- `fetch_pc` and `rsp_pc` are loaded with {`redirect_pc`[31:2], 2'b00}.
- `drop_cnt` is set to `outstanding` minus 1 if a response arrives this cycle, otherwise to `outstanding`. That response is dropped.
- `outstanding` updates normally.
- No request is issued in the redirect cycle.
- Back-to-back redirects: the most recent one wins; drop accounting accumulates correctly.

Reset:
- `fetch_pc` and `rsp_pc` = `RESET_PC`.
- `count`, `outstanding` and `drop_cnt` = 0.
- Outputs: `mem_req_valid` = 0, `out_valid` = 0, `out_instr` = 0, `out_pc` = 0, `mem_req_addr` = `RESET_PC`.
- Reset mid-operation abandons in-flight requests. The memory is reset together with this block, so no stale response arrives afterwards.

## Timing
- First request: the cycle after `reset` deasserts.
- Latency, response to `out_valid`: 1 cycle, since the response is registered into the FIFO.
- Redirect to first new request: 1 cycle. New instructions appear no earlier than memory latency + 1 after that request.
- Full FIFO (count = DEPTH): `mem_req_valid` stays low. Issue resumes the cycle after the pop that frees credit.
- FIFO pointers wrap modulo DEPTH. `fetch_pc` wraps from 32'hFFFF_FFFC to 0.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined:
  - When count = 0 and a non-dropped response arrives, `out_valid`, `out_instr` and `out_pc` show it combinationally in the same cycle.
  - If `out_ready` is also high, the response is consumed without being written into the FIFO.
  - A redirect in that cycle suppresses the bypass.
- Undefined: all responses pass through the FIFO, giving the 1-cycle latency above. Outputs are driven from registered state only.

## Test plan
- Reset with `RESET_PC`=0, 1-cycle memory, `out_ready`=1 → requests at 0,4,8,…; `out_pc` sequence 0,4,8 with matching memory words; steady state one instruction per cycle.
- Hold `out_ready`=0 with DEPTH=4 → exactly 4 entries filled, `mem_req_valid` then low. Release → PCs 0..12 delivered in order with no duplicates or gaps.
- 3-cycle memory latency with 2 requests outstanding; assert redirect to 32'h100 → both stale responses dropped; next `out_pc` = 32'h100.
- Redirect in the same cycle as a response and a pop → FIFO empty next cycle; response dropped; `drop_cnt` equals remaining outstanding.
- `redirect_pc` = 32'h0000_0203 → `mem_req_addr` = 32'h0000_0200.
- With `FETCH_QUEUE_BYPASS_EN`, empty queue, response at PC 8 and `out_ready`=1 → `out_valid`=1 in the same cycle and `count` remains 0. Without the macro → `out_valid` rises the following cycle.
